// File: rtl/bulls_cows_pkg.sv
// Shared types and helpers for the Bulls & Cows engine: game phase enum and digit slicing.
package bulls_cows_pkg;

    localparam int unsigned PhaseW = 2;

    typedef enum logic [PhaseW-1:0] {
        SECRET = 2'd0,
        GUESS  = 2'd1,
        DONE   = 2'd2
    } phase_t;

    // Digit 0 sits in the MSBs of a packed code.
    function automatic int unsigned digit_lsb(input int unsigned idx,
                                              input int unsigned n_digits,
                                              input int unsigned digit_w);
        return (n_digits - 1 - idx) * digit_w;
    endfunction

endpackage

// File: rtl/bulls_cows_scorer.sv
// Combinational scorer: bulls/cows of code_b against code_a, plus range/distinctness check of code_b.
module bulls_cows_scorer
    import bulls_cows_pkg::*;
#(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned DIGIT_W  = 4,
    parameter int unsigned BASE     = 10
) (
    input  logic [N_DIGITS*DIGIT_W-1:0]   code_a_i,
    input  logic [N_DIGITS*DIGIT_W-1:0]   code_b_i,
    output logic [$clog2(N_DIGITS+1)-1:0] bulls_o,
    output logic [$clog2(N_DIGITS+1)-1:0] cows_o,
    output logic                          valid_b_o
);

    localparam int unsigned CntW = $clog2(N_DIGITS + 1);

    logic [DIGIT_W-1:0] dig_a [N_DIGITS];
    logic [DIGIT_W-1:0] dig_b [N_DIGITS];
    int unsigned        bull_cnt;
    int unsigned        cow_cnt;
    logic               ok;

    always_comb begin
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            dig_a[i] = code_a_i[digit_lsb(i, N_DIGITS, DIGIT_W) +: DIGIT_W];
            dig_b[i] = code_b_i[digit_lsb(i, N_DIGITS, DIGIT_W) +: DIGIT_W];
        end
    end

    // Cows assume distinct digits in both codes, which validation guarantees for scored entries.
    always_comb begin
        bull_cnt = 0;
        cow_cnt  = 0;
        ok       = 1'b1;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (dig_a[i] == dig_b[i]) bull_cnt = bull_cnt + 1;
            if (32'(dig_b[i]) >= BASE) ok = 1'b0;
            for (int unsigned j = 0; j < N_DIGITS; j++) begin
                if (i != j) begin
                    if (dig_b[i] == dig_a[j]) cow_cnt = cow_cnt + 1;
                    if (dig_b[i] == dig_b[j]) ok = 1'b0;
                end
            end
        end
    end

    assign bulls_o   = CntW'(bull_cnt);
    assign cows_o    = CntW'(cow_cnt);
    assign valid_b_o = ok;

endmodule

// File: rtl/bulls_cows_engine.sv
// N-player Bulls & Cows controller: secret collection, rotating guesses, scoring, win/draw detection.
module bulls_cows_engine
    import bulls_cows_pkg::*;
#(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned BASE       = 10,
    parameter int unsigned N_PLAYERS  = 2,
    parameter int unsigned MAX_ROUNDS = 15
) (
    input  logic                            clock_i,
    input  logic                            reset_ni,
    input  logic [N_DIGITS*DIGIT_W-1:0]     guess_i,
    input  logic                            confirm_i,
    output logic [$clog2(N_DIGITS+1)-1:0]   bulls_o,
    output logic [$clog2(N_DIGITS+1)-1:0]   cows_o,
    output logic                            result_valid_o,
    output logic                            entry_error_o,
    output phase_t                          phase_o,
    output logic [$clog2(N_PLAYERS)-1:0]    player_o,
    output logic [$clog2(MAX_ROUNDS+1)-1:0] round_o,
    output logic                            game_over_o,
    output logic [$clog2(N_PLAYERS)-1:0]    winner_o,
    output logic                            draw_o
);

    localparam int unsigned CodeW   = N_DIGITS * DIGIT_W;
    localparam int unsigned CntW    = $clog2(N_DIGITS + 1);
    localparam int unsigned PlayerW = $clog2(N_PLAYERS);
    localparam int unsigned RoundW  = $clog2(MAX_ROUNDS + 1);

    logic               confirm_q;
    phase_t             phase_q, phase_d;
    logic [PlayerW-1:0] player_q, player_d;
    logic [RoundW-1:0]  round_q, round_d;
    logic [CntW-1:0]    bulls_q, bulls_d;
    logic [CntW-1:0]    cows_q, cows_d;
    logic               result_valid_q, result_valid_d;
    logic               entry_error_q, entry_error_d;
    logic [PlayerW-1:0] winner_q, winner_d;
    logic               draw_q, draw_d;
    logic [CodeW-1:0]   secret_q [N_PLAYERS];
    logic [CodeW-1:0]   secret_d [N_PLAYERS];

    logic               submit;
    logic               last_player;
    logic [PlayerW-1:0] target;
    logic [CntW-1:0]    score_bulls;
    logic [CntW-1:0]    score_cows;
    logic               code_ok;

    assign submit      = confirm_i & ~confirm_q;
    assign last_player = (player_q == PlayerW'(N_PLAYERS - 1));
    assign target      = last_player ? '0 : player_q + 1'b1;

    // Single scorer: validates the entry in every phase and scores it in GUESS.
    bulls_cows_scorer #(
        .N_DIGITS (N_DIGITS),
        .DIGIT_W  (DIGIT_W),
        .BASE     (BASE)
    ) u_scorer (
        .code_a_i  (secret_q[target]),
        .code_b_i  (guess_i),
        .bulls_o   (score_bulls),
        .cows_o    (score_cows),
        .valid_b_o (code_ok)
    );

    always_comb begin
        phase_d        = phase_q;
        player_d       = player_q;
        round_d        = round_q;
        bulls_d        = bulls_q;
        cows_d         = cows_q;
        winner_d       = winner_q;
        draw_d         = draw_q;
        secret_d       = secret_q;
        result_valid_d = 1'b0;
        entry_error_d  = 1'b0;

        if (submit) begin
            case (phase_q)
                SECRET: begin
                    if (!code_ok) begin
                        entry_error_d = 1'b1;
                    end else begin
                        secret_d[player_q] = guess_i;
                        if (last_player) begin
                            phase_d  = GUESS;
                            player_d = '0;
                            round_d  = RoundW'(1);
                        end else begin
                            player_d = player_q + 1'b1;
                        end
                    end
                end
                GUESS: begin
                    if (!code_ok) begin
                        entry_error_d = 1'b1;
                    end else begin
                        bulls_d        = score_bulls;
                        cows_d         = score_cows;
                        result_valid_d = 1'b1;
                        if (score_bulls == CntW'(N_DIGITS)) begin
                            phase_d  = DONE;
                            winner_d = player_q;
                        end else if (last_player) begin
                            player_d = '0;
                            if (round_q == RoundW'(MAX_ROUNDS)) begin
                                phase_d = DONE;
                                draw_d  = 1'b1;
                            end else begin
                                round_d = round_q + 1'b1;
                            end
                        end else begin
                            player_d = player_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    phase_d  = SECRET;
                    player_d = '0;
                    round_d  = '0;
                    bulls_d  = '0;
                    cows_d   = '0;
                    winner_d = '0;
                    draw_d   = 1'b0;
                    for (int i = 0; i < int'(N_PLAYERS); i++) secret_d[i] = '0;
                end
                default: phase_d = SECRET;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            confirm_q      <= 1'b0;
            phase_q        <= SECRET;
            player_q       <= '0;
            round_q        <= '0;
            bulls_q        <= '0;
            cows_q         <= '0;
            result_valid_q <= 1'b0;
            entry_error_q  <= 1'b0;
            winner_q       <= '0;
            draw_q         <= 1'b0;
            for (int i = 0; i < int'(N_PLAYERS); i++) secret_q[i] <= '0;
        end else begin
            confirm_q      <= confirm_i;
            phase_q        <= phase_d;
            player_q       <= player_d;
            round_q        <= round_d;
            bulls_q        <= bulls_d;
            cows_q         <= cows_d;
            result_valid_q <= result_valid_d;
            entry_error_q  <= entry_error_d;
            winner_q       <= winner_d;
            draw_q         <= draw_d;
            secret_q       <= secret_d;
        end
    end

    assign bulls_o        = bulls_q;
    assign cows_o         = cows_q;
    assign result_valid_o = result_valid_q;
    assign entry_error_o  = entry_error_q;
    assign phase_o        = phase_q;
    assign player_o       = player_q;
    assign round_o        = round_q;
    assign game_over_o    = (phase_q == DONE);
    assign winner_o       = winner_q;
    assign draw_o         = draw_q;

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Bench for bulls_cows_engine: default 2-player DUT plus a 3-player/2-round DUT, checked by a game model.
module tb_bulls_cows_engine;
    import bulls_cows_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] guess0, guess1;
    logic        conf0, conf1;
    logic [2:0]  bulls0, cows0, bulls1, cows1;
    logic        rv0, err0, rv1, err1;
    phase_t      ph0, ph1;
    logic [0:0]  player0, winner0;
    logic [1:0]  player1, winner1;
    logic [3:0]  round0;
    logic [1:0]  round1;
    logic        go0, go1, draw0, draw1;

    int total = 0;
    int bad   = 0;
    int nstep = 0;

    bulls_cows_engine u_dut0 (
        .clock_i        (clk),
        .reset_ni       (rst_n),
        .guess_i        (guess0),
        .confirm_i      (conf0),
        .bulls_o        (bulls0),
        .cows_o         (cows0),
        .result_valid_o (rv0),
        .entry_error_o  (err0),
        .phase_o        (ph0),
        .player_o       (player0),
        .round_o        (round0),
        .game_over_o    (go0),
        .winner_o       (winner0),
        .draw_o         (draw0)
    );

    bulls_cows_engine #(
        .N_PLAYERS  (3),
        .MAX_ROUNDS (2)
    ) u_dut1 (
        .clock_i        (clk),
        .reset_ni       (rst_n),
        .guess_i        (guess1),
        .confirm_i      (conf1),
        .bulls_o        (bulls1),
        .cows_o         (cows1),
        .result_valid_o (rv1),
        .entry_error_o  (err1),
        .phase_o        (ph1),
        .player_o       (player1),
        .round_o        (round1),
        .game_over_o    (go1),
        .winner_o       (winner1),
        .draw_o         (draw1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    phase_t      m_phase  [2];
    int          m_player [2];
    int          m_round  [2];
    int          m_bulls  [2];
    int          m_cows   [2];
    int          m_winner [2];
    bit          m_draw   [2];
    bit          m_rv     [2];
    bit          m_err    [2];
    logic [15:0] m_sec    [2][3];

    function automatic int nplayers(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int maxrounds(input int d);
        return (d == 0) ? 15 : 2;
    endfunction

    function automatic int dig(input logic [15:0] c, input int i);
        logic [15:0] s;
        s = (c >> (12 - 4 * i)) & 16'h000f;
        return int'(s);
    endfunction

    function automatic bit code_valid(input logic [15:0] c);
        bit [15:0] seen;
        int v;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            v = dig(c, i);
            if (v >= 10) return 1'b0;
            if (seen[v]) return 1'b0;
            seen[v] = 1'b1;
        end
        return 1'b1;
    endfunction

    function automatic int count_bulls(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (dig(a, i) == dig(b, i)) n++;
        return n;
    endfunction

    // Digits shared as sets, regardless of position.
    function automatic int count_common(input logic [15:0] a, input logic [15:0] b);
        bit [15:0] sa, sb;
        sa = '0;
        sb = '0;
        for (int i = 0; i < 4; i++) begin
            sa[dig(a, i)] = 1'b1;
            sb[dig(b, i)] = 1'b1;
        end
        return $countones(sa & sb);
    endfunction

    task automatic model_reset(input int d);
        m_phase[d]  = SECRET;
        m_player[d] = 0;
        m_round[d]  = 0;
        m_bulls[d]  = 0;
        m_cows[d]   = 0;
        m_winner[d] = 0;
        m_draw[d]   = 1'b0;
        m_rv[d]     = 1'b0;
        m_err[d]    = 1'b0;
        for (int p = 0; p < 3; p++) m_sec[d][p] = '0;
    endtask

    task automatic model_apply(input int d, input logic [15:0] code);
        int np, tgt, b;
        np       = nplayers(d);
        m_rv[d]  = 1'b0;
        m_err[d] = 1'b0;
        case (m_phase[d])
            SECRET: begin
                if (!code_valid(code)) begin
                    m_err[d] = 1'b1;
                end else begin
                    m_sec[d][m_player[d]] = code;
                    if (m_player[d] == np - 1) begin
                        m_phase[d]  = GUESS;
                        m_player[d] = 0;
                        m_round[d]  = 1;
                    end else begin
                        m_player[d]++;
                    end
                end
            end
            GUESS: begin
                if (!code_valid(code)) begin
                    m_err[d] = 1'b1;
                end else begin
                    tgt        = (m_player[d] + 1) % np;
                    b          = count_bulls(m_sec[d][tgt], code);
                    m_bulls[d] = b;
                    m_cows[d]  = count_common(m_sec[d][tgt], code) - b;
                    m_rv[d]    = 1'b1;
                    if (b == 4) begin
                        m_phase[d]  = DONE;
                        m_winner[d] = m_player[d];
                    end else if (m_player[d] == np - 1) begin
                        m_player[d] = 0;
                        if (m_round[d] == maxrounds(d)) begin
                            m_phase[d] = DONE;
                            m_draw[d]  = 1'b1;
                        end else begin
                            m_round[d]++;
                        end
                    end else begin
                        m_player[d]++;
                    end
                end
            end
            default: model_reset(d);
        endcase
    endtask

    function automatic int o_player(input int d);
        return (d == 0) ? int'(player0) : int'(player1);
    endfunction
    function automatic int o_round(input int d);
        return (d == 0) ? int'(round0) : int'(round1);
    endfunction
    function automatic int o_winner(input int d);
        return (d == 0) ? int'(winner0) : int'(winner1);
    endfunction
    function automatic int o_bulls(input int d);
        return (d == 0) ? int'(bulls0) : int'(bulls1);
    endfunction
    function automatic int o_cows(input int d);
        return (d == 0) ? int'(cows0) : int'(cows1);
    endfunction

    function automatic logic [15:0] rand_valid();
        int p[10];
        int k, t;
        for (int i = 0; i < 10; i++) p[i] = i;
        for (int i = 9; i > 0; i--) begin
            k    = int'($urandom_range(i, 0));
            t    = p[i];
            p[i] = p[k];
            p[k] = t;
        end
        return {4'(p[0]), 4'(p[1]), 4'(p[2]), 4'(p[3])};
    endfunction

    // One submit on DUT d, then a full output check one clock after the submit edge.
    task automatic step(input int d, input logic [15:0] code);
        logic exp_go;
        nstep++;
        model_apply(d, code);
        @(negedge clk);
        if (d == 0) begin guess0 = code; conf0 = 1'b1; end
        else        begin guess1 = code; conf1 = 1'b1; end
        @(negedge clk);
        conf0  = 1'b0;
        conf1  = 1'b0;
        exp_go = (m_phase[d] == DONE);
        total++;
        if ((d == 0 ? rv0 : rv1) !== m_rv[d]) begin
            bad++;
            $display("FAIL step%0d dut%0d result_valid code=%h got=%0b want=%0b", nstep, d, code,
                     (d == 0 ? rv0 : rv1), m_rv[d]);
        end
        total++;
        if ((d == 0 ? err0 : err1) !== m_err[d]) begin
            bad++;
            $display("FAIL step%0d dut%0d entry_error code=%h got=%0b want=%0b", nstep, d, code,
                     (d == 0 ? err0 : err1), m_err[d]);
        end
        total++;
        if ((d == 0 ? ph0 : ph1) !== m_phase[d]) begin
            bad++;
            $display("FAIL step%0d dut%0d phase got=%0d want=%0d", nstep, d,
                     (d == 0 ? ph0 : ph1), m_phase[d]);
        end
        total++;
        if (o_player(d) != m_player[d]) begin
            bad++;
            $display("FAIL step%0d dut%0d player got=%0d want=%0d", nstep, d, o_player(d),
                     m_player[d]);
        end
        total++;
        if (o_round(d) != m_round[d]) begin
            bad++;
            $display("FAIL step%0d dut%0d round got=%0d want=%0d", nstep, d, o_round(d),
                     m_round[d]);
        end
        total++;
        if ((d == 0 ? go0 : go1) !== exp_go) begin
            bad++;
            $display("FAIL step%0d dut%0d game_over got=%0b want=%0b", nstep, d,
                     (d == 0 ? go0 : go1), exp_go);
        end
        total++;
        if ((d == 0 ? draw0 : draw1) !== m_draw[d]) begin
            bad++;
            $display("FAIL step%0d dut%0d draw got=%0b want=%0b", nstep, d,
                     (d == 0 ? draw0 : draw1), m_draw[d]);
        end
        total++;
        if (o_bulls(d) != m_bulls[d] || o_cows(d) != m_cows[d]) begin
            bad++;
            $display("FAIL step%0d dut%0d score code=%h got=%0d/%0d want=%0d/%0d", nstep, d, code,
                     o_bulls(d), o_cows(d), m_bulls[d], m_cows[d]);
        end
        if (exp_go && !m_draw[d]) begin
            total++;
            if (o_winner(d) != m_winner[d]) begin
                bad++;
                $display("FAIL step%0d dut%0d winner got=%0d want=%0d", nstep, d, o_winner(d),
                         m_winner[d]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic check_reset_values(input string tag);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ((d == 0 ? ph0 : ph1) !== SECRET || o_player(d) != 0 || o_round(d) != 0 ||
                o_bulls(d) != 0 || o_cows(d) != 0 || o_winner(d) != 0 ||
                (d == 0 ? {rv0, err0, go0, draw0} : {rv1, err1, go1, draw1}) !== 4'b0000) begin
                bad++;
                $display("FAIL %s dut%0d got phase=%0d player=%0d round=%0d b=%0d c=%0d want all 0",
                         tag, d, (d == 0 ? ph0 : ph1), o_player(d), o_round(d), o_bulls(d),
                         o_cows(d));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset_held");
        rst_n = 1'b1;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        check_reset_values("reset_released");
    endtask

    task automatic test_invalid_entry();
        step(0, 16'h1123);
        step(0, 16'h12A4);
        @(negedge clk);
        total++;
        if (err0 !== 1'b0) begin
            bad++;
            $display("FAIL error_pulse_width got=%0b want=0", err0);
        end
    endtask

    task automatic test_secret_entry();
        step(0, 16'h1234);
        step(0, 16'h5678);
    endtask

    task automatic test_scoring();
        step(0, 16'h5687);
        @(negedge clk);
        total++;
        if (rv0 !== 1'b0 || bulls0 !== 3'd2 || cows0 !== 3'd2) begin
            bad++;
            $display("FAIL result_hold got rv=%0b b=%0d c=%0d want rv=0 b=2 c=2", rv0, bulls0,
                     cows0);
        end
        step(0, 16'h1234);
    endtask

    task automatic test_done_restart();
        step(0, 16'h1111);
    endtask

    task automatic test_held_confirm();
        int pulses;
        step(0, 16'h1234);
        step(0, 16'h5678);
        model_apply(0, 16'h5687);
        pulses = 0;
        @(negedge clk);
        guess0 = 16'h5687;
        conf0  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rv0 === 1'b1) pulses++;
        end
        conf0 = 1'b0;
        @(negedge clk);
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL held_confirm result_valid pulses got=%0d want=1", pulses);
        end
        total++;
        if (o_player(0) != m_player[0] || o_round(0) != m_round[0]) begin
            bad++;
            $display("FAIL held_confirm player/round got=%0d/%0d want=%0d/%0d", o_player(0),
                     o_round(0), m_player[0], m_round[0]);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(0);
        model_reset(1);
        step(0, 16'h4321);
    endtask

    task automatic test_draw();
        step(1, 16'h0123);
        step(1, 16'h4567);
        step(1, 16'h8901);
        repeat (6) step(1, 16'h9876);
    endtask

    task automatic test_random();
        int d, r;
        logic [15:0] code;
        for (int n = 0; n < 120; n++) begin
            d = n % 2;
            r = int'($urandom_range(7, 0));
            if (r == 0)
                code = 16'($urandom());
            else if (r == 1 && m_phase[d] == GUESS)
                code = m_sec[d][(m_player[d] + 1) % nplayers(d)];
            else
                code = rand_valid();
            step(d, code);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        guess0 = '0;
        guess1 = '0;
        conf0  = 1'b0;
        conf1  = 1'b0;
        test_reset();
        test_invalid_entry();
        test_secret_entry();
        test_scoring();
        test_done_restart();
        test_held_confirm();
        test_async_reset();
        test_draw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
